// File: rtl/text_overlay_sched.sv
// text_overlay_sched
//   Per-scanline scheduler for the 8x8 glyph dot stage of the text overlay.
//   It follows the beam against a fixed text window and prefetches each
//   character one column ahead. The character code comes from the text
//   buffer, then the 64-bit bitmap comes from the font ROM. The bitmap, glyph
//   column and glyph row are delivered in step with the dot stage's 2-cycle
//   pipeline.
//
// Ports
//   clk, rst         pixel clock, synchronous active-high reset
//   pix_valid        active video (pix_x advances by 1 per cycle while high)
//   pix_x, pix_y     current pixel column / scanline
//   text_addr        text buffer read address (row*COLS+col)
//   text_code        text buffer data, valid 1 cycle after text_addr
//   font_req         one-cycle font ROM read strobe
//   font_code        glyph index for the ROM read
//   font_bits        glyph bitmap, valid ROM_LAT cycles after font_req
//   char_h, char_v   glyph column / row to the dot stage
//   char_out         glyph bitmap to the dot stage (0 outside the window)
//   ovl_valid        dot stage output lies inside the window
//   err_miss         pulse: column boundary reached without a fetched bitmap
module text_overlay_sched #(
  parameter int X0      = 64,
  parameter int Y0      = 32,
  parameter int COLS    = 16,
  parameter int ROWS    = 4,
  parameter int AW      = 6,
  parameter int ROM_LAT = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pix_valid,
  input  logic [10:0]   pix_x,
  input  logic [10:0]   pix_y,
  output logic [AW-1:0] text_addr,
  input  logic [7:0]    text_code,
  output logic          font_req,
  output logic [7:0]    font_code,
  input  logic [63:0]   font_bits,
  output logic [2:0]    char_h,
  output logic [2:0]    char_v,
  output logic [63:0]   char_out,
  output logic          ovl_valid,
  output logic          err_miss
);

  // Window bounds are widened to 12 bits so that the upper edges cannot wrap.
  localparam logic [11:0]   X_LO   = 12'(X0);
  localparam logic [11:0]   X_HI   = 12'(X0 + 8*COLS);
  localparam logic [11:0]   T_LO   = 12'(X0 - 8);
  localparam logic [11:0]   T_SPAN = 12'(8*COLS);
  localparam logic [11:0]   Y_LO   = 12'(Y0);
  localparam logic [11:0]   Y_HI   = 12'(Y0 + 8*ROWS);
  localparam logic [10:0]   Y0_11  = 11'(Y0);
  localparam logic [2:0]    X0_LO  = 3'(X0);
  localparam logic [2:0]    LAT    = 3'(ROM_LAT);
  localparam logic [AW-1:0] COLS_A = AW'(COLS);

  // S_ADDR covers the cycle in which text_addr is on the bus and the text
  // buffer has not yet answered. The code is captured in S_CODE.
  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_CODE, S_REQ, S_WAIT} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] text_addr_q, text_addr_d;
  logic [7:0]    code_q, code_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [63:0]   next_bits_q, next_bits_d;
  logic          next_valid_q, next_valid_d;
  logic [63:0]   cur_bits_q, cur_bits_d;
  logic          err_miss_q, err_miss_d;
  logic [2:0]    char_h_q, char_h_d;
  logic [2:0]    char_v_q, char_v_d;
  logic          d1_q, d1_d;
  logic [63:0]   char_out_q, char_out_d;
  logic          d2_q, d2_d;
  logic          ovl_q, ovl_d;

  logic [11:0] px, py, trel;
  logic [10:0] rel_y;
  logic [2:0]  rel_x_lo;
  logic        in_x, in_y, in_win, trig, boundary, latch;

  always_comb begin
    px       = {1'b0, pix_x};
    py       = {1'b0, pix_y};
    in_x     = (px >= X_LO) && (px < X_HI);
    in_y     = (py >= Y_LO) && (py < Y_HI);
    in_win   = pix_valid && in_x && in_y;
    rel_x_lo = pix_x[2:0] - X0_LO;
    rel_y    = pix_y - Y0_11;
    // Column k is fetched while the beam sits at X0+8k-8, one column early.
    trel     = px - T_LO;
    trig     = pix_valid && in_y && (px >= T_LO) && (trel < T_SPAN) &&
               (trel[2:0] == 3'd0);
    boundary = in_win && (rel_x_lo == 3'd0);
    latch    = (state_q == S_WAIT) && (cnt_q == 3'd1);
  end

  // Fetch FSM plus the current/next bitmap handoff.
  always_comb begin
    state_d      = state_q;
    text_addr_d  = text_addr_q;
    code_d       = code_q;
    cnt_d        = cnt_q;
    next_bits_d  = next_bits_q;
    next_valid_d = next_valid_q;
    cur_bits_d   = cur_bits_q;
    err_miss_d   = 1'b0;
    font_req     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (trig) begin
          text_addr_d = AW'(rel_y[10:3]) * COLS_A + AW'(trel[11:3]);
          state_d     = S_ADDR;
        end
      end
      S_ADDR: state_d = S_CODE;
      S_CODE: begin
        code_d  = text_code;
        state_d = S_REQ;
      end
      S_REQ: begin
        font_req = 1'b1;
        cnt_d    = LAT;
        state_d  = S_WAIT;
      end
      S_WAIT: begin
        // The counter reaches 1 in the cycle that font_bits becomes valid.
        if (cnt_q == 3'd1) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (boundary) begin
      if (latch) begin
        // The bitmap arrives on the boundary edge itself, so it goes
        // straight into cur_bits.
        cur_bits_d = font_bits;
      end else if (next_valid_q) begin
        cur_bits_d   = next_bits_q;
        next_valid_d = 1'b0;
      end else begin
        cur_bits_d = 64'd0;
        err_miss_d = 1'b1;
      end
    end else if (latch) begin
      next_bits_d  = font_bits;
      next_valid_d = 1'b1;
    end
  end

  // Output pipeline aligned with the dot stage.
  always_comb begin
    char_h_d   = rel_x_lo;
    char_v_d   = rel_y[2:0];
    d1_d       = in_win;
    char_out_d = d1_q ? cur_bits_q : 64'd0;
    d2_d       = d1_q;
    ovl_d      = d2_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      text_addr_q  <= '0;
      code_q       <= 8'd0;
      cnt_q        <= 3'd0;
      next_bits_q  <= 64'd0;
      next_valid_q <= 1'b0;
      cur_bits_q   <= 64'd0;
      err_miss_q   <= 1'b0;
      char_h_q     <= 3'd0;
      char_v_q     <= 3'd0;
      d1_q         <= 1'b0;
      char_out_q   <= 64'd0;
      d2_q         <= 1'b0;
      ovl_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      text_addr_q  <= text_addr_d;
      code_q       <= code_d;
      cnt_q        <= cnt_d;
      next_bits_q  <= next_bits_d;
      next_valid_q <= next_valid_d;
      cur_bits_q   <= cur_bits_d;
      err_miss_q   <= err_miss_d;
      char_h_q     <= char_h_d;
      char_v_q     <= char_v_d;
      d1_q         <= d1_d;
      char_out_q   <= char_out_d;
      d2_q         <= d2_d;
      ovl_q        <= ovl_d;
    end
  end

  assign text_addr = text_addr_q;
  assign font_code = code_q;
  assign char_h    = char_h_q;
  assign char_v    = char_v_q;
  assign char_out  = char_out_q;
  assign ovl_valid = ovl_q;
  assign err_miss  = err_miss_q;

endmodule

// File: tb/tb_text_overlay_sched.sv
// Testbench for text_overlay_sched with default parameters. It models a
// 1-cycle text buffer and a 2-cycle font ROM, and it records the outputs of
// each scanline cycle by cycle. Cycle index c corresponds to pixel
// x = xs + c. The bench checks a table of per-line totals and then a few
// hand-written timing sequences.
module tb_text_overlay_sched;

  localparam int NC = 160;

  logic        clk = 1'b0;
  logic        rst;
  logic        pix_valid;
  logic [10:0] pix_x, pix_y;
  logic [5:0]  text_addr;
  logic [7:0]  text_code;
  logic        font_req;
  logic [7:0]  font_code;
  logic [63:0] font_bits;
  logic [2:0]  char_h, char_v;
  logic [63:0] char_out;
  logic        ovl_valid, err_miss;

  always #5 clk = ~clk;

  text_overlay_sched dut (
    .clk(clk), .rst(rst), .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
    .text_addr(text_addr), .text_code(text_code), .font_req(font_req),
    .font_code(font_code), .font_bits(font_bits), .char_h(char_h),
    .char_v(char_v), .char_out(char_out), .ovl_valid(ovl_valid),
    .err_miss(err_miss)
  );

  function automatic logic [63:0] glyph(input logic [7:0] c);
    return (c == 8'h41) ? 64'h183C66667E666600 : ({8{c}} ^ 64'h0123456789ABCDEF);
  endfunction

  logic [7:0]  tbuf [64];
  logic [63:0] rom_s1;
  logic        rom_v1;

  // Text buffer: registered read. Font ROM: 2-cycle latency, with filler
  // data outside the valid cycle so that a mistimed latch is caught.
  always @(posedge clk) begin
    text_code <= tbuf[text_addr];
    rom_s1    <= glyph(font_code);
    rom_v1    <= font_req;
    font_bits <= rom_v1 ? rom_s1 : 64'hA5A55A5AF00F0FF0;
  end

  logic [5:0]  r_addr [NC];
  logic        r_req  [NC];
  logic [7:0]  r_code [NC];
  logic [2:0]  r_h    [NC];
  logic [2:0]  r_v    [NC];
  logic [63:0] r_out  [NC];
  logic        r_ovl  [NC];
  logic        r_miss [NC];

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Scan one line from xs to x=200, then run idle cycles. rst is asserted
  // during cycle rst_c (use -1 for none).
  task automatic run_line(input int y, input int xs, input int rst_c);
    for (int c = 0; c < NC; c++) begin
      r_addr[c] = text_addr;
      r_req[c]  = font_req;
      r_code[c] = font_code;
      r_h[c]    = char_h;
      r_v[c]    = char_v;
      r_out[c]  = char_out;
      r_ovl[c]  = ovl_valid;
      r_miss[c] = err_miss;
      rst   = (c == rst_c);
      pix_y = 11'(y);
      if (xs + c <= 200) begin
        pix_valid = 1'b1;
        pix_x     = 11'(xs + c);
      end else begin
        pix_valid = 1'b0;
        pix_x     = 11'd0;
      end
      @(posedge clk); #1;
    end
    rst = 1'b0;
  endtask

  typedef struct {
    int y;
    int xs;
    int n_req;
    int n_ovl;
    int n_miss;
    int n_nz;
    bit chk_addr;
    int addr;
  } vec_t;

  vec_t tbl [6];

  initial begin
    int cnt;
    int sr, so, sm, sn;

    tbl[0] = '{y:32, xs:56, n_req:16, n_ovl:128, n_miss:0, n_nz:128, chk_addr:1, addr:0};
    tbl[1] = '{y:61, xs:56, n_req:16, n_ovl:128, n_miss:0, n_nz:128, chk_addr:1, addr:48};
    tbl[2] = '{y:32, xs:64, n_req:15, n_ovl:128, n_miss:1, n_nz:120, chk_addr:1, addr:1};
    tbl[3] = '{y:31, xs:56, n_req:0,  n_ovl:0,   n_miss:0, n_nz:0,   chk_addr:0, addr:0};
    tbl[4] = '{y:64, xs:56, n_req:0,  n_ovl:0,   n_miss:0, n_nz:0,   chk_addr:0, addr:0};
    tbl[5] = '{y:39, xs:56, n_req:16, n_ovl:128, n_miss:0, n_nz:128, chk_addr:1, addr:0};

    for (int i = 0; i < 64; i++) tbuf[i] = (i == 0) ? 8'h41 : 8'(8'h80 + i);

    // Reset with random inputs: every output must read 0.
    pix_valid = 1'b0; pix_x = 11'd0; pix_y = 11'd0; rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      pix_valid = 1'($urandom_range(0, 1));
      pix_x     = 11'($urandom_range(0, 2047));
      pix_y     = 11'($urandom_range(0, 2047));
      @(posedge clk); #1;
      chk("reset_outputs",
          64'({text_addr, font_req, font_code, char_h, char_v, ovl_valid, err_miss}), 64'd0);
      chk("reset_char_out", char_out, 64'd0);
    end
    rst = 1'b0; pix_valid = 1'b0;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      cnt += int'(font_req);
    end
    chk("idle_no_font_req", 64'(cnt), 64'd0);
    $display("reset sequence done");

    // Single glyph timing, y=32, x=56..200.
    run_line(32, 56, -1);
    chk("A_text_addr_T1", 64'(r_addr[1]), 64'd0);
    chk("A_font_req_T2", 64'(r_req[2]), 64'd0);
    chk("A_font_req_T3", 64'(r_req[3]), 64'd1);
    chk("A_font_code_T3", 64'(r_code[3]), 64'h41);
    chk("A_font_req_T4", 64'(r_req[4]), 64'd0);
    chk("A_char_out_before", r_out[9], 64'd0);
    chk("A_char_out_glyph", r_out[10], 64'h183C66667E666600);
    chk("A_ovl_before", 64'(r_ovl[10]), 64'd0);
    cnt = 0;
    for (int c = 11; c <= 138; c++) cnt += int'(r_ovl[c]);
    chk("A_ovl_run", 64'(cnt), 64'd128);
    chk("A_ovl_after", 64'(r_ovl[139]), 64'd0);
    $display("seq single glyph done");

    // Addressing: y=61, column 15.
    run_line(61, 56, -1);
    chk("B_text_addr_col15", 64'(r_addr[121]), 64'd63);
    chk("B_char_v", 64'(r_v[129]), 64'd5);
    for (int j = 0; j < 8; j++) chk("B_char_h", 64'(r_h[129 + j]), 64'(j));
    $display("seq addressing done");

    // Missed lead-in: start at x=64.
    run_line(32, 64, -1);
    chk("C_err_miss_pre", 64'(r_miss[0]), 64'd0);
    chk("C_err_miss", 64'(r_miss[1]), 64'd1);
    chk("C_err_miss_post", 64'(r_miss[2]), 64'd0);
    cnt = 0;
    for (int c = 2; c <= 9; c++) cnt += int'(r_out[c] != 64'd0);
    chk("C_col0_blank", 64'(cnt), 64'd0);
    chk("C_col1_glyph", r_out[10], glyph(8'h81));
    $display("seq missed lead-in done");

    // Reset mid-fetch: rst high in cycle T+2.
    run_line(32, 56, 2);
    chk("D_outputs_zero",
        64'({r_addr[3], r_req[3], r_code[3], r_h[3], r_v[3], r_ovl[3], r_miss[3]}), 64'd0);
    chk("D_char_out_zero", r_out[3], 64'd0);
    cnt = 0;
    for (int c = 0; c <= 7; c++) cnt += int'(r_req[c]);
    chk("D_no_aborted_req", 64'(cnt), 64'd0);
    chk("D_addr_next", 64'(r_addr[9]), 64'd1);
    chk("D_req_next", 64'(r_req[11]), 64'd1);
    chk("D_code_next", 64'(r_code[11]), 64'h81);
    chk("D_miss_col0", 64'(r_miss[9]), 64'd1);
    chk("D_no_stale", r_out[10], 64'd0);
    chk("D_col1_glyph", r_out[18], glyph(8'h81));
    $display("seq reset mid-fetch done");

    // Table of whole-line totals.
    for (int i = 0; i < 6; i++) begin
      run_line(tbl[i].y, tbl[i].xs, -1);
      sr = 0; so = 0; sm = 0; sn = 0;
      for (int c = 0; c < NC; c++) begin
        sr += int'(r_req[c]);
        so += int'(r_ovl[c]);
        sm += int'(r_miss[c]);
        sn += int'(r_out[c] != 64'd0);
      end
      chk("T_font_req_count", 64'(sr), 64'(tbl[i].n_req));
      chk("T_ovl_count", 64'(so), 64'(tbl[i].n_ovl));
      chk("T_miss_count", 64'(sm), 64'(tbl[i].n_miss));
      chk("T_char_out_nz", 64'(sn), 64'(tbl[i].n_nz));
      if (tbl[i].chk_addr) chk("T_first_addr", 64'(r_addr[1]), 64'(tbl[i].addr));
      $display("line y=%0d xs=%0d req=%0d ovl=%0d miss=%0d nz=%0d",
               tbl[i].y, tbl[i].xs, sr, so, sm, sn);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/text_overlay_sched.md
# text_overlay_sched

Per-scanline scheduler that drives the 8x8 glyph dot stage of the text overlay. It tracks the incoming pixel position against a fixed text window and prefetches each character: first its code from the text buffer, then its 64-bit bitmap from the font ROM, one character ahead of the beam. It then presents `char_h`, `char_v` and the bitmap to the dot stage, timed to that stage's 2-cycle pipeline. `ovl_valid` marks the cycles in which the dot stage output belongs to the window.

## Interface
Parameters:
- `X0`, default 64: left pixel column of the window. Must be ≥ 8 to leave the lead-in fetch slot.
- `Y0`, default 32: top scanline of the window.
- `COLS`, default 16: characters per text row.
- `ROWS`, default 4: text rows.
- `AW`, default 6: text buffer address width. Requires COLS*ROWS ≤ 2^AW.
- `ROM_LAT`, default 2: font ROM read latency in cycles. Legal range 1..4.

Ports:
- `clk`  in  1: pixel clock, single clock domain.
- `rst`  in  1: synchronous, active-high reset.
- `pix_valid`  in  1: active video. While high, `pix_x` increments by 1 per cycle.
- `pix_x`  in  11: current pixel column.
- `pix_y`  in  11: current scanline.
- `text_addr`  out  AW: text buffer read address, computed as row*COLS+col.
- `text_code`  in  8: text buffer data. Valid exactly 1 cycle after `text_addr`.
- `font_req`  out  1: one-cycle font ROM read strobe.
- `font_code`  out  8: glyph index for the ROM read.
- `font_bits`  in  64: glyph bitmap, row 0 in bits [63:56] with MSB leftmost. Valid in cycle `font_req`+ROM_LAT.
- `char_h`  out  3: glyph column to the dot stage.
- `char_v`  out  3: glyph row to the dot stage.
- `char_out`  out  64: bitmap to the dot stage.
- `ovl_valid`  out  1: dot stage output is inside the window.
- `err_miss`  out  1: one-cycle pulse when a character boundary is reached with no fetched bitmap.

## Operation
- A pixel is in the window when `pix_valid` is high and X0 ≤ `pix_x` < X0+8*COLS and Y0 ≤ `pix_y` < Y0+8*ROWS.
- In-window position:
  - rel_x = `pix_x`-X0 and rel_y = `pix_y`-Y0, both 11-bit.
  - col = rel_x>>3, row = rel_y>>3.
- Fetch trigger for column k (0 ≤ k < COLS): `pix_valid` high, `pix_y` in band, and `pix_x` = X0+8k-8. There is no trigger for k = COLS.
- FSM, with T as the trigger cycle:
  - IDLE: on a trigger, register `text_addr`=row*COLS+k and go to CODE. This is cycle T+1.
  - CODE (T+2): capture `text_code` and go to REQ.
  - REQ (T+3): `font_req`=1 and `font_code`=captured code. Load the wait counter with ROM_LAT and go to WAIT.
  - WAIT: count down. In cycle T+3+ROM_LAT, latch `font_bits` into next_bits, set next_valid and go to IDLE.
- A trigger that arrives while the FSM is not in IDLE is ignored.
- A fetch in progress always completes, even if `pix_valid` drops.
- Column boundary, on the edge sampling `pix_x`=X0+8k in window:
  - If next_valid is set: cur_bits ← next_bits and next_valid is cleared.
  - Otherwise: cur_bits ← 0 (blank glyph) and `err_miss` pulses in the following cycle.
  - If the latch and the boundary fall in the same cycle, cur_bits ← `font_bits` directly (bypass) and next_valid stays clear.
- Output pipeline, for a pixel sampled in cycle t:
  - Stage 1 (t+1): `char_h`=rel_x[2:0], `char_v`=rel_y[2:0], in-window flag d1.
  - Stage 2 (t+2): `char_out`=cur_bits if d1, else 0. Flag d2.
  - Stage 3 (t+3): `ovl_valid`=d2. This aligns with the dot stage output.
- Outside the window, `char_h` and `char_v` still follow the rel_x/rel_y low bits. `char_out` is 0.

## Timing
- Reset values:
  - `text_addr`=0, `font_req`=0, `font_code`=0.
  - `char_h`=0, `char_v`=0, `char_out`=0.
  - `ovl_valid`=0, `err_miss`=0.
  - Internal: FSM=IDLE, next_valid=0, cur_bits=0, next_bits=0, flags=0.
- `rst` asserted mid-fetch aborts the fetch. Outputs show reset values in the cycle after the `rst` edge, and no `font_req` is issued for the aborted fetch.
- Fetch completes at T+3+ROM_LAT ≤ T+7, which is before the boundary at T+8. Back-to-back columns never overlap.
- Pixel-to-`ovl_valid` latency is 3 cycles.

## Test plan
All scenarios use the default parameters.
- Reset: hold `rst` 3 cycles with random inputs -> every output 0. After release with `pix_valid`=0, no `font_req`.
- Single glyph: buffer[0]=0x41 and font(0x41)=0x183C66667E666600. Scan y=32, x=56..200.
  - `text_addr`=0 at T+1 (T is the x=56 cycle).
  - `font_req` with code 0x41 at T+3.
  - `char_out`=glyph from the x=64 cycle +2.
  - `ovl_valid` high for 128 cycles starting at the x=64 cycle +3.
- Addressing: y=61, column 15 -> `text_addr`=63 and `char_v`=5. `char_h` counts 0..7 across the column.
- Missed lead-in: start `pix_valid` at x=64 on y=32 ->
  - `err_miss` pulse at the x=64 cycle +1.
  - `char_out`=0 for column 0.
  - Column 1 shows its glyph normally.
- Reset mid-fetch: assert `rst` at T+2 ->
  - No `font_req`; outputs 0 next cycle.
  - After release, the next trigger fetches normally and next_valid is not stale.
- Out of window: scan y=31 and y=64 full lines -> no `font_req`, `ovl_valid`=0, `char_out`=0.
